// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: valid/ready value handshake into the display scanner
interface seg7_scan_mux_if;
  logic [15:0] i_Value;
  logic        i_Value_Valid;
  logic        o_Value_Ready;
  modport master (output i_Value, output i_Value_Valid, input o_Value_Ready);
  modport slave (input i_Value, input i_Value_Valid, output o_Value_Ready);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit 7-segment scanner with frame-aligned value updates
module seg7_scan_mux #(
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int BLANK_CLKS     = 500
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  seg7_scan_mux_if.slave        bus,
  input  logic                  i_Blank_Zeros,
  output logic [3:0]            o_Binary_Num,
  output logic [3:0]            o_Digit_En_n,
  output logic                  o_Frame_Start
);
  localparam int M0 = CLKS_PER_DIGIT > BLANK_CLKS ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CW = $clog2(M0 > 2 ? M0 : 2);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS == 0 ? 0 : BLANK_CLKS - 1);
  typedef enum logic {S_SHOW, S_BLANK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          accept, slot_end, adv, wrap, blank;
  always_comb begin
    accept      = bus.i_Value_Valid && !pend_full_q;
    slot_end    = state_q == S_SHOW ? cnt_q == SHOW_LAST : cnt_q == BLANK_LAST;
    adv         = slot_end && (state_q == S_BLANK || BLANK_CLKS == 0);
    wrap        = adv && idx_q == 2'd3;
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    state_d     = adv ? S_SHOW : slot_end ? S_BLANK : state_q;
    idx_d       = adv ? idx_q + 2'd1 : idx_q;
    disp_d      = wrap && pend_full_q ? pend_q : disp_q;
    pend_d      = accept ? bus.i_Value : pend_q;
    pend_full_d = accept || (pend_full_q && !wrap);
    // leading-zero blanking: this nibble and every higher one are zero
    blank         = i_Blank_Zeros && idx_q != 2'd0 && (disp_q >> {idx_q, 2'b00}) == 16'h0;
    o_Binary_Num  = disp_q[{idx_q, 2'b00} +: 4];
    o_Digit_En_n  = state_q == S_SHOW && !blank ? ~(4'b0001 << idx_q) : 4'b1111;
    o_Frame_Start = state_q == S_SHOW && idx_q == 2'd0 && cnt_q == '0;
  end
  assign bus.o_Value_Ready = !pend_full_q;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= S_SHOW;
      idx_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed table plus random stimulus against a time-based display model
module tb_seg7_scan_mux;
  localparam int CPD = 4;
  logic clk = 0, rst = 1, bz = 0;
  logic [3:0] num_a, en_a, num_b, en_b;
  logic fs_a, fs_b;
  int checks = 0, errors = 0;
  bit saw_off_b = 0;
  seg7_scan_mux_if ifa ();
  seg7_scan_mux_if ifb ();
  seg7_scan_mux #(.CLKS_PER_DIGIT(CPD), .BLANK_CLKS(2)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .bus(ifa.slave), .i_Blank_Zeros(bz),
    .o_Binary_Num(num_a), .o_Digit_En_n(en_a), .o_Frame_Start(fs_a));
  seg7_scan_mux #(.CLKS_PER_DIGIT(CPD), .BLANK_CLKS(0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .bus(ifb.slave), .i_Blank_Zeros(bz),
    .o_Binary_Num(num_b), .o_Digit_En_n(en_b), .o_Frame_Start(fs_b));
  always #5 clk = ~clk;
  typedef struct {
    int n; logic rst, valid; logic [15:0] val; logic bz;
    logic [3:0] num, en; logic fs, rdy;
  } vec_t;
  // model: position in frame, displayed value, one-entry pending slot
  int mt[2];
  logic [15:0] md[2], mp[2];
  bit mf[2];
  function automatic int per(int k);
    return CPD + (k == 0 ? 2 : 0);
  endfunction
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_check(int k);
    int p, dg;
    logic [15:0] sh;
    logic [3:0] e, an, ae;
    logic af, ar;
    p  = per(k);
    dg = mt[k] / p;
    sh = md[k] >> (4 * dg);
    e  = 4'hF;
    if ((mt[k] % p) < CPD && !(bz && dg != 0 && sh == 0)) e[dg] = 1'b0;
    an = k == 0 ? num_a : num_b;
    ae = k == 0 ? en_a : en_b;
    af = k == 0 ? fs_a : fs_b;
    ar = k == 0 ? ifa.o_Value_Ready : ifb.o_Value_Ready;
    chk(k == 0 ? "model_num_a" : "model_num_b", 16'(an), 16'(sh[3:0]));
    chk(k == 0 ? "model_en_a" : "model_en_b", 16'(ae), 16'(e));
    chk(k == 0 ? "model_fs_a" : "model_fs_b", 16'(af), 16'(mt[k] == 0));
    chk(k == 0 ? "model_rdy_a" : "model_rdy_b", 16'(ar), 16'(!mf[k]));
  endtask
  task automatic model_edge(int k, logic r, logic v, logic [15:0] val);
    int nt;
    bit acc;
    if (r) begin
      mt[k] = 0; md[k] = 0; mf[k] = 0;
    end else begin
      nt  = (mt[k] + 1) % (4 * per(k));
      acc = v && !mf[k];
      if (nt == 0 && mf[k]) begin md[k] = mp[k]; mf[k] = 0; end
      if (acc) begin mp[k] = val; mf[k] = 1; end
      mt[k] = nt;
    end
  endtask
  task automatic tick(vec_t r, bit do_model, bit do_tab);
    rst = r.rst; bz = r.bz;
    ifa.i_Value_Valid = r.valid; ifb.i_Value_Valid = r.valid;
    ifa.i_Value = r.val; ifb.i_Value = r.val;
    #1;
    if (do_model) begin
      model_check(0);
      model_check(1);
      if (!bz && en_b == 4'hF) saw_off_b = 1;
    end
    if (do_tab) begin
      chk("tab_num", 16'(num_a), 16'(r.num));
      chk("tab_en", 16'(en_a), 16'(r.en));
      chk("tab_fs", 16'(fs_a), 16'(r.fs));
      chk("tab_rdy", 16'(ifa.o_Value_Ready), 16'(r.rdy));
    end
    @(posedge clk);
    model_edge(0, r.rst, r.valid, r.val);
    model_edge(1, r.rst, r.valid, r.val);
    @(negedge clk);
  endtask
  vec_t tab[$];
  vec_t rv;
  initial begin
    tab = '{
      '{5, 0, 0, 16'h0000, 0, 4'h0, 4'hE, 1, 1},
      '{1, 0, 1, 16'h1234, 0, 4'h0, 4'hF, 0, 1},
      '{18, 0, 0, 16'h0000, 0, 4'h0, 4'hD, 0, 0},
      '{1, 0, 0, 16'h0000, 0, 4'h4, 4'hE, 1, 1},
      '{17, 0, 0, 16'h0000, 0, 4'h4, 4'hE, 0, 1},
      '{1, 0, 0, 16'h0000, 0, 4'h1, 4'h7, 0, 1},
      '{5, 0, 0, 16'h0000, 0, 4'h1, 4'h7, 0, 1},
      '{5, 0, 0, 16'h0000, 0, 4'h4, 4'hE, 1, 1},
      '{1, 0, 1, 16'h5678, 0, 4'h4, 4'hF, 0, 1},
      '{18, 0, 1, 16'hABCD, 0, 4'h3, 4'hD, 0, 0},
      '{1, 0, 1, 16'hABCD, 0, 4'h8, 4'hE, 1, 1},
      '{23, 0, 0, 16'h0000, 0, 4'h8, 4'hE, 0, 0},
      '{1, 0, 0, 16'h0000, 0, 4'hD, 4'hE, 1, 1},
      '{1, 0, 1, 16'h0050, 1, 4'hD, 4'hE, 0, 1},
      '{22, 0, 0, 16'h0000, 1, 4'hD, 4'hE, 0, 0},
      '{6, 0, 0, 16'h0000, 1, 4'h0, 4'hE, 1, 1},
      '{6, 0, 0, 16'h0000, 1, 4'h5, 4'hD, 0, 1},
      '{6, 0, 0, 16'h0000, 1, 4'h0, 4'hF, 0, 1},
      '{1, 0, 1, 16'h0000, 1, 4'h0, 4'hF, 0, 1},
      '{5, 0, 0, 16'h0000, 1, 4'h0, 4'hF, 0, 0},
      '{6, 0, 0, 16'h0000, 1, 4'h0, 4'hE, 1, 1},
      '{6, 0, 0, 16'h0000, 1, 4'h0, 4'hF, 0, 1},
      '{4, 0, 1, 16'h9999, 0, 4'h0, 4'hB, 0, 1},
      '{1, 1, 0, 16'h0000, 0, 4'h0, 4'hF, 0, 0},
      '{24, 0, 0, 16'h0000, 0, 4'h0, 4'hE, 1, 1},
      '{1, 1, 1, 16'h7777, 0, 4'h0, 4'hE, 1, 1},
      '{24, 0, 0, 16'h0000, 0, 4'h0, 4'hE, 1, 1},
      '{1, 0, 0, 16'h0000, 0, 4'h0, 4'hE, 1, 1}
    };
    for (int k = 0; k < 2; k++) begin mt[k] = 0; md[k] = 0; mp[k] = 0; mf[k] = 0; end
    @(negedge clk);
    rv = '{1, 1, 0, 16'h0, 0, 4'h0, 4'h0, 0, 0};
    tick(rv, 0, 0);
    tick(rv, 0, 0);
    for (int i = 0; i < tab.size(); i++)
      for (int j = 0; j < tab[i].n; j++) tick(tab[i], 1, j == 0);
    for (int i = 0; i < 800; i++) begin
      rv.rst   = $urandom_range(0, 99) == 0;
      rv.valid = $urandom_range(0, 3) == 0;
      rv.val   = 16'($urandom);
      rv.bz    = $urandom_range(0, 1) == 1;
      tick(rv, 1, 0);
    end
    chk("no_blank_gap_b", 16'(saw_off_b), 16'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed scanner for a 4-digit common-anode 7-segment display. Holds a 16-bit display value, cycles through its four nibbles, and presents one nibble per slot on `o_Binary_Num` to the downstream hex-to-segment decoder, together with active-low digit enables. New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
Parameters:
- `CLKS_PER_DIGIT`, default 50000: clocks each digit is driven; must be ≥ 1.
- `BLANK_CLKS`, default 500: all-digits-off clocks after each digit (anti-ghosting); must be ≥ 0.

Ports:
- `i_Clk`, input, 1: the block's single clock.
- `i_Rst`, input, 1: synchronous, active-high reset.
- `i_Value`, input, 16: value to display; nibble k is digit k, digit 0 = bits [3:0].
- `i_Value_Valid`, input, 1: upstream offers `i_Value`.
- `o_Value_Ready`, output, 1: high when the pending register is empty.
- `i_Blank_Zeros`, input, 1: enables leading-zero blanking.
- `o_Binary_Num`, output, 4: current digit nibble, to the decoder.
- `o_Digit_En_n`, output, 4: active-low one-hot digit enables.
- `o_Frame_Start`, output, 1: one-cycle pulse on the first cycle of digit 0.

## Operation
- Registers:
  - `disp` (16 bits): the displayed value.
  - `pend` (16 bits) plus `pend_full`.
  - State: `S_SHOW` or `S_BLANK`.
  - Digit index `idx` (2 bits).
  - Slot counter `cnt`, sized `clog2(max(CLKS_PER_DIGIT, BLANK_CLKS, 2))`.
- Handshake:
  - Accept when `i_Value_Valid && o_Value_Ready`: `pend <= i_Value`, `pend_full <= 1`.
  - `o_Value_Ready = !pend_full`.
  - While the pending register is full, `i_Value_Valid` is ignored; upstream holds its value.
- State machine:
  - `S_SHOW`: `cnt` counts 0..`CLKS_PER_DIGIT-1`. At the last count, `cnt <= 0`, then:
    - go to `S_BLANK` if `BLANK_CLKS > 0`;
    - otherwise advance the digit directly.
  - `S_BLANK`: `cnt` counts 0..`BLANK_CLKS-1`. At the last count, `cnt <= 0` and advance the digit.
- Advancing the digit:
  - `idx <= idx+1` (wraps 3→0); state goes to `S_SHOW`.
  - On wrap to 0 with `pend_full`: `disp <= pend`, `pend_full <= 0`.
- Outputs are decoded combinationally from registered state:
  - `o_Binary_Num = disp[4*idx +: 4]` in both states.
  - `o_Digit_En_n = ~(4'b0001 << idx)` in `S_SHOW`, except 4'b1111 when the digit is blanked.
  - `o_Digit_En_n = 4'b1111` in `S_BLANK`.
  - `o_Frame_Start = (S_SHOW && idx==0 && cnt==0)`.
- Leading-zero blanking:
  - Applies when `i_Blank_Zeros = 1`, `idx ≠ 0`, and nibbles idx..3 of `disp` are all zero.
  - Digit 0 is never blanked.
  - Slot timing is unchanged by blanking.
- Reset (synchronous) sets:
  - `S_SHOW`, `idx = 0`, `cnt = 0`;
  - `disp = 0`, `pend_full = 0`.
  - Accepts are ignored while `i_Rst` is high.
- Reset values of outputs:
  - `o_Digit_En_n = 4'b1110`, `o_Binary_Num = 0`;
  - `o_Frame_Start = 1`, `o_Value_Ready = 1`.

## Timing
- Digit period = `CLKS_PER_DIGIT + BLANK_CLKS` cycles; frame = 4 × digit period.
- Accept at edge N: `o_Value_Ready` is low from cycle N+1.
- The value becomes visible in the next `o_Frame_Start` cycle; `o_Value_Ready` is high in that same cycle.
- Accept on the same edge as the frame wrap:
  - `pend` was empty, so there is no transfer on that edge.
  - The value is shown one full frame later.
- Reset mid-frame, including during `S_BLANK` or with a pending value:
  - The pending value is dropped.
  - Outputs return to reset values in the cycle after the reset edge.
- Counters wrap only as specified; `idx` is never out of range.

## Test plan
(`CLKS_PER_DIGIT=4`, `BLANK_CLKS=2`, 24-cycle frame unless noted.)
- Reset then idle → `o_Digit_En_n` repeats 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, 1111×2; `o_Frame_Start` every 24 cycles; `o_Binary_Num = 0`.
- Send 0x1234 at cycle 5 → ready low from cycle 6; display still 0 until cycle 24. At cycle 24: `o_Binary_Num = 4`, `En_n = 1110`, ready = 1. Digit 3 slot shows 1.
- Send 0x1234 at cycle 5, then hold valid with 0xABCD → 0xABCD accepted at cycle 24 and shown from cycle 48; 0x1234 displayed for exactly frame 24–47.
- `i_Blank_Zeros=1`, value 0x0050 → digits 0 and 1 enabled, digit 2/3 slots stay 1111. Value 0x0000 → only digit 0 enabled, showing 0.
- `BLANK_CLKS=0` → `En_n` never 1111; frame = 16 cycles.
- Reset asserted during `S_BLANK` of digit 2 with a value pending → next cycle: `En_n = 1110`, `o_Binary_Num = 0`, ready = 1, `o_Frame_Start = 1`; the old pending value is never shown.
